// File: rtl/serial_byte_deserializer_pkg.sv
// Shared constants and small helpers for the serial byte deserializer.
package serial_byte_deserializer_pkg;

  localparam int BYTE_W = 8;
  localparam int CNT_W  = 3;

  // Bit-order encodings for the MSB_FIRST parameter.
  localparam logic BIT_ORDER_LSB_FIRST = 1'b0;
  localparam logic BIT_ORDER_MSB_FIRST = 1'b1;

  // Count value of the last bit of a byte.
  localparam logic [CNT_W-1:0] CNT_LAST = 3'd7;

  // Two-input OR gate primitive used for the any-bit accumulate step.
  function automatic logic or_gate(input logic a, input logic b);
    return a | b;
  endfunction

  // Shift one serial bit into the assembly register in the selected order.
  function automatic logic [BYTE_W-1:0] shift_in(input logic              msb_first,
                                                 input logic [BYTE_W-1:0] cur,
                                                 input logic              b);
    logic [BYTE_W-1:0] nxt;
    if (msb_first) begin
      nxt = {cur[BYTE_W-2:0], b};
    end else begin
      nxt = {b, cur[BYTE_W-1:1]};
    end
    return nxt;
  endfunction

endpackage

// File: rtl/serial_byte_deserializer_byte_holding_reg.sv
// Output holding register: loads completed bytes, drops them when full and
// unconsumed (raising a sticky overrun flag), and clears valid on consume.
module byte_holding_reg
  import serial_byte_deserializer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic [BYTE_W-1:0] load_data,
  input  logic              load_any,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_any,
  output logic              overrun
);

  logic [BYTE_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              any_q, any_d;
  logic              overrun_q, overrun_d;
  logic              can_load_s;

  // Next-state for load, drop-with-overrun and consume.
  always_comb begin
    data_d     = data_q;
    valid_d    = valid_q;
    any_d      = any_q;
    overrun_d  = overrun_q;
    can_load_s = (!valid_q) || out_ready;
    if (load_req) begin
      if (can_load_s) begin
        data_d  = load_data;
        any_d   = load_any;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Holding register state with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q    <= {BYTE_W{1'b0}};
      valid_q   <= 1'b0;
      any_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      any_q     <= any_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_any   = any_q;
  assign overrun   = overrun_q;

endmodule

// File: rtl/serial_byte_deserializer.sv
// Bit-serial to byte converter with valid/ready output and a running
// any-bit-set flag accumulated as the bits arrive.
module serial_byte_deserializer
  import serial_byte_deserializer_pkg::*;
#(
  parameter logic MSB_FIRST  = BIT_ORDER_LSB_FIRST,
  parameter logic IDLE_CLEAR = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_any,
  output logic              busy,
  output logic              overrun
);

  logic [BYTE_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              any_acc_q, any_acc_d;
  logic              busy_q, busy_d;

  logic [CNT_W-1:0]  cnt_base_s;
  logic              acc_base_s;
  logic              complete_s;
  logic [BYTE_W-1:0] comp_byte_s;
  logic              comp_any_s;

  // Shift/count/accumulate next-state; frame_start rebases the count before
  // the current bit is applied so a coincident bit becomes bit 0.
  always_comb begin
    cnt_base_s = bit_cnt_q;
    acc_base_s = any_acc_q;
    if (frame_start) begin
      cnt_base_s = {CNT_W{1'b0}};
      if (IDLE_CLEAR || (bit_cnt_q != {CNT_W{1'b0}})) begin
        acc_base_s = 1'b0;
      end else begin
        acc_base_s = any_acc_q;
      end
    end else begin
      cnt_base_s = bit_cnt_q;
    end

    comp_byte_s = shift_in(MSB_FIRST, shift_q, bit_in);
    comp_any_s  = or_gate(acc_base_s, bit_in);

    shift_d    = shift_q;
    bit_cnt_d  = cnt_base_s;
    any_acc_d  = acc_base_s;
    complete_s = 1'b0;
    if (bit_valid) begin
      shift_d   = comp_byte_s;
      bit_cnt_d = cnt_base_s + 3'd1;
      if (cnt_base_s == CNT_LAST) begin
        complete_s = 1'b1;
        any_acc_d  = 1'b0;
      end else begin
        any_acc_d = comp_any_s;
      end
    end else begin
      shift_d = shift_q;
    end

    busy_d = (bit_cnt_d != {CNT_W{1'b0}});
  end

  // Collection state with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q   <= {BYTE_W{1'b0}};
      bit_cnt_q <= {CNT_W{1'b0}};
      any_acc_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      any_acc_q <= any_acc_d;
      busy_q    <= busy_d;
    end
  end

  assign busy = busy_q;

  byte_holding_reg u_hold (
    .clk       (clk),
    .rst       (rst),
    .load_req  (complete_s),
    .load_data (comp_byte_s),
    .load_any  (comp_any_s),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_any   (out_any),
    .overrun   (overrun)
  );

endmodule

// File: tb/tb_serial_byte_deserializer.sv
// Bench for serial_byte_deserializer: one LSB-first and one MSB-first instance
// share the same serial stream; a queue holds the bytes expected to appear.
module tb_serial_byte_deserializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_start = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       out_ready = 1'b0;

  logic [7:0] data0, data1;
  logic       valid0, valid1, any0, any1, busy0, busy1, ovr0, ovr1;
  logic [11:0] st0, st1;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  serial_byte_deserializer #(.MSB_FIRST(1'b0), .IDLE_CLEAR(1'b1)) dut0 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .bit_in(bit_in),
    .bit_valid(bit_valid), .out_ready(out_ready), .out_data(data0),
    .out_valid(valid0), .out_any(any0), .busy(busy0), .overrun(ovr0));

  serial_byte_deserializer #(.MSB_FIRST(1'b1), .IDLE_CLEAR(1'b1)) dut1 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .bit_in(bit_in),
    .bit_valid(bit_valid), .out_ready(out_ready), .out_data(data1),
    .out_valid(valid1), .out_any(any1), .busy(busy1), .overrun(ovr1));

  // Packed status: {valid, any, busy, overrun, data}
  assign st0 = {valid0, any0, busy0, ovr0, data0};
  assign st1 = {valid1, any1, busy1, ovr1, data1};

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    bit_valid = 1'b0; frame_start = 1'b0; out_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
  endtask

  // Drive eight bits of b, b[0] first; optionally frame_start on bit 0 and
  // out_ready only on the last bit.
  task automatic send_byte(input logic [7:0] b, input bit fs_first, input bit rdy_last, input bit push);
    if (push) exp_q.push_back(b);
    for (int i = 0; i < 8; i++) begin
      bit_in = b[i];
      bit_valid = 1'b1;
      frame_start = (i == 0) && fs_first;
      if (rdy_last) out_ready = (i == 7);
      step();
    end
    bit_valid = 1'b0;
    frame_start = 1'b0;
    if (rdy_last) out_ready = 1'b0;
  endtask

  task automatic send_bits(input int n, input logic v);
    for (int i = 0; i < n; i++) begin
      bit_in = v; bit_valid = 1'b1; step();
    end
    bit_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
    n_tests++;
    if (st0 !== 12'h000) begin n_fail++; $display("FAIL reset_dut0: got %h expected %h", st0, 12'h000); end
    n_tests++;
    if (st1 !== 12'h000) begin n_fail++; $display("FAIL reset_dut1: got %h expected %h", st1, 12'h000); end
  endtask

  task automatic test_basic();
    logic [7:0] e;
    out_ready = 1'b0;
    send_bits(7, 1'b0);
    n_tests++;
    if (valid0 !== 1'b0 || busy0 !== 1'b1) begin n_fail++; $display("FAIL basic_pre_valid: got v=%b busy=%b expected v=0 busy=1", valid0, busy0); end
    apply_reset();
    send_byte(8'h85, 1'b0, 1'b0, 1'b1);
    if (exp_q.size() == 0) begin n_tests++; n_fail++; $display("FAIL basic_sb: got empty queue expected entry"); end
    else begin
      e = exp_q.pop_front();
      n_tests++;
      if (st0 !== {1'b1, |e, 1'b0, 1'b0, e}) begin n_fail++; $display("FAIL basic_dut0: got %h expected %h", st0, {1'b1, |e, 1'b0, 1'b0, e}); end
      n_tests++;
      if (st1 !== {1'b1, |e, 1'b0, 1'b0, rev8(e)}) begin n_fail++; $display("FAIL basic_dut1: got %h expected %h", st1, {1'b1, |e, 1'b0, 1'b0, rev8(e)}); end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_tests++;
    if (valid0 !== 1'b0 || data0 !== 8'h85 || any0 !== 1'b1) begin n_fail++; $display("FAIL basic_consume: got v=%b d=%h a=%b expected v=0 d=85 a=1", valid0, data0, any0); end
  endtask

  task automatic test_zero_pulse();
    logic [7:0] e;
    out_ready = 1'b1;
    send_byte(8'h00, 1'b0, 1'b0, 1'b1);
    e = exp_q.pop_front();
    n_tests++;
    if (st0 !== {1'b1, 1'b0, 1'b0, 1'b0, e}) begin n_fail++; $display("FAIL zero_dut0: got %h expected %h", st0, {1'b1, 1'b0, 1'b0, 1'b0, e}); end
    step();
    n_tests++;
    if (valid0 !== 1'b0 || valid1 !== 1'b0) begin n_fail++; $display("FAIL zero_pulse: got v0=%b v1=%b expected 0 0", valid0, valid1); end
    out_ready = 1'b0;
  endtask

  task automatic test_overrun();
    logic [7:0] e;
    out_ready = 1'b0;
    send_byte(8'hFF, 1'b0, 1'b0, 1'b1);
    e = exp_q.pop_front();
    n_tests++;
    if (st0 !== {1'b1, 1'b1, 1'b0, 1'b0, e}) begin n_fail++; $display("FAIL ovr_first: got %h expected %h", st0, {1'b1, 1'b1, 1'b0, 1'b0, e}); end
    send_byte(8'h01, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (st0 !== 12'hD_FF) begin n_fail++; $display("FAIL ovr_drop_dut0: got %h expected %h", st0, 12'hDFF); end
    n_tests++;
    if (st1 !== 12'hD_FF) begin n_fail++; $display("FAIL ovr_drop_dut1: got %h expected %h", st1, 12'hDFF); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_tests++;
    if (valid0 !== 1'b0 || ovr0 !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got v=%b o=%b expected v=0 o=1", valid0, ovr0); end
    apply_reset();
    n_tests++;
    if (ovr0 !== 1'b0) begin n_fail++; $display("FAIL ovr_rst_clear: got %b expected 0", ovr0); end
  endtask

  task automatic test_frame_start();
    logic [7:0] e;
    out_ready = 1'b0;
    send_bits(5, 1'b1);
    n_tests++;
    if (busy0 !== 1'b1) begin n_fail++; $display("FAIL fs_busy: got %b expected 1", busy0); end
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    n_tests++;
    if (busy0 !== 1'b0) begin n_fail++; $display("FAIL fs_idle: got %b expected 0", busy0); end
    send_byte(8'h3C, 1'b0, 1'b0, 1'b1);
    e = exp_q.pop_front();
    n_tests++;
    if (st0 !== {1'b1, 1'b1, 1'b0, 1'b0, e}) begin n_fail++; $display("FAIL fs_sep_dut0: got %h expected %h", st0, {1'b1, 1'b1, 1'b0, 1'b0, e}); end
    n_tests++;
    if (st1 !== {1'b1, 1'b1, 1'b0, 1'b0, rev8(e)}) begin n_fail++; $display("FAIL fs_sep_dut1: got %h expected %h", st1, {1'b1, 1'b1, 1'b0, 1'b0, rev8(e)}); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    send_bits(5, 1'b1);
    send_byte(8'h00, 1'b1, 1'b0, 1'b1);
    e = exp_q.pop_front();
    n_tests++;
    if (st0 !== {1'b1, 1'b0, 1'b0, 1'b0, e}) begin n_fail++; $display("FAIL fs_coinc_dut0: got %h expected %h", st0, {1'b1, 1'b0, 1'b0, 1'b0, e}); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_msb_and_simul();
    logic [7:0] e;
    out_ready = 1'b0;
    send_byte(8'h01, 1'b0, 1'b0, 1'b1);
    e = exp_q.pop_front();
    n_tests++;
    if (data1 !== 8'h80 || valid1 !== 1'b1) begin n_fail++; $display("FAIL msb_first: got d=%h v=%b expected d=80 v=1", data1, valid1); end
    n_tests++;
    if (data0 !== e) begin n_fail++; $display("FAIL lsb_first: got %h expected %h", data0, e); end
    send_byte(8'h5A, 1'b0, 1'b1, 1'b1);
    e = exp_q.pop_front();
    n_tests++;
    if (st0 !== {1'b1, 1'b1, 1'b0, 1'b0, e}) begin n_fail++; $display("FAIL simul_dut0: got %h expected %h", st0, {1'b1, 1'b1, 1'b0, 1'b0, e}); end
    n_tests++;
    if (st1 !== {1'b1, 1'b1, 1'b0, 1'b0, rev8(e)}) begin n_fail++; $display("FAIL simul_dut1: got %h expected %h", st1, {1'b1, 1'b1, 1'b0, 1'b0, rev8(e)}); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] pat [3];
    logic [7:0] e;
    pat[0] = 8'hA7; pat[1] = 8'h10; pat[2] = 8'hE2;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send_byte(pat[k], 1'b0, 1'b0, 1'b1);
      e = exp_q.pop_front();
      n_tests++;
      if (st0 !== {1'b1, |e, 1'b0, 1'b0, e}) begin n_fail++; $display("FAIL b2b_%0d_dut0: got %h expected %h", k, st0, {1'b1, |e, 1'b0, 1'b0, e}); end
      n_tests++;
      if (st1 !== {1'b1, |e, 1'b0, 1'b0, rev8(e)}) begin n_fail++; $display("FAIL b2b_%0d_dut1: got %h expected %h", k, st1, {1'b1, |e, 1'b0, 1'b0, rev8(e)}); end
    end
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [7:0] e;
    out_ready = 1'b0;
    send_byte(8'h96, 1'b0, 1'b0, 1'b1);
    e = exp_q.pop_front();
    n_tests++;
    if (data0 !== e) begin n_fail++; $display("FAIL arst_pre: got %h expected %h", data0, e); end
    send_bits(4, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    n_tests++;
    if (st0 !== 12'h000) begin n_fail++; $display("FAIL arst_dut0: got %h expected %h", st0, 12'h000); end
    n_tests++;
    if (st1 !== 12'h000) begin n_fail++; $display("FAIL arst_dut1: got %h expected %h", st1, 12'h000); end
    #1;
    rst = 1'b0;
    send_byte(8'hC3, 1'b0, 1'b0, 1'b1);
    e = exp_q.pop_front();
    n_tests++;
    if (st0 !== {1'b1, 1'b1, 1'b0, 1'b0, e}) begin n_fail++; $display("FAIL arst_clean: got %h expected %h", st0, {1'b1, 1'b1, 1'b0, 1'b0, e}); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_pulse();
    test_overrun();
    test_frame_start();
    test_msb_and_simul();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
